fmul_pipe: RTL and testbench
============================

# fmul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the successor to the fixed 32-bit FMUL block. Format width is generic, all four rounding modes are runtime-selectable, and the block adds exception flags, a transaction tag, and valid/ready backpressure on both sides. It sits between an operand-issue stage and a result-writeback stage. The DPI C reference model checks it in the DPI bench.

## Interface
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored mantissa (fraction) width
- TAG_W, 4, width of the opaque tag carried alongside each operation
- DATA_W (local, not overridable) = 1+EXP_W+MAN_W

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- op1  in  DATA_W  multiplicand
- op2  in  DATA_W  multiplier
- r_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
- tag_in  in  TAG_W  tag, returned unchanged with the result
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_W  product
- tag_out  out  TAG_W  tag of the current result
- flags  out  4  {NV invalid, OF overflow, UF underflow, NX inexact}

## Operation
- Three-stage pipeline:
  - S1: unpack, classify, sign = s1^s2, exponent sum.
  - S2: (MAN_W+1)x(MAN_W+1) significand multiply.
  - S3: normalise, round, special-case select, pack, flag generation.
- A transfer occurs on a cycle with valid && ready. r_mode and tag_in are sampled with the operands.
- Global stall: en = !out_valid || out_ready; in_ready = en. All stages advance only when en. Bubbles are not collapsed.
- Denormal inputs are treated as signed zero (DAZ). NX is not set for this substitution.
- NaN input returns the canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
  - NV is set if either input is a signalling NaN (fraction MSB 0, fraction nonzero).
- Inf x 0 (either order) returns canonical qNaN with NV set.
- Inf x finite-nonzero, or Inf x Inf, returns signed Inf with no flags.
- Zero x finite returns signed zero with no flags.
- Normal path:
  - Product P is 2*(MAN_W+1) bits.
  - If the P MSB is set, shift right 1 and add 1 to the exponent.
  - exp = e1 + e2 - bias + norm.
  - Guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - RNE: ties to even. RTZ: truncate. RUP: increment if inexact and positive. RDN: increment if inexact and negative.
  - If the rounding carry overflows the mantissa, re-normalise and add 1 to the exponent.
  - NX = guard | sticky.
- Overflow (final biased exp >= 2^EXP_W-1): OF and NX are set.
  - RNE returns signed Inf.
  - RTZ returns signed max-finite.
  - RUP returns +Inf if positive, -max-finite if negative.
  - RDN returns -Inf if negative, +max-finite if positive.
- Underflow (final biased exp <= 0): flush to signed zero with UF and NX set. No subnormal outputs.

## Timing
- Latency: result appears 3 cycles after the accepting edge when out_ready stays high. Throughput is 1 op/cycle.
- Reset values: out_valid 0, result 0, tag_out 0, flags 0, all internal stage valids 0.
  - in_ready is 1 in the first cycle after reset release.
- Reset asserted mid-operation drops every in-flight operation silently. No partial result is emitted.
- While out_valid && !out_ready, the following hold stable and no new beat is accepted: result, tag_out, flags, out_valid.
  - in_ready is 0 in the same cycle (combinational from out_valid/out_ready).
- A simultaneous output handshake and input handshake in one cycle is legal. Both complete and the pipeline shifts.
- Results are returned strictly in issue order.
- flags are valid only when out_valid is high. They are per-operation and never sticky.

## Test plan
- 3F800000 x 40000000, RNE, out_ready=1: result 40000000, flags 0, out_valid exactly 3 cycles after accept.
- 7F800000 x 00000000: result 7FC00000, flags NV. Also 7F800001 x 3F800000: result 7FC00000, NV.
- 7F7FFFFF x 40000000: RNE gives 7F800000 with OF|NX. RTZ gives 7F7FFFFF with OF|NX. Sign-flipped op1 in RUP gives FF7FFFFF.
- 3F800001 x 3F800001: RNE gives 3F800002 (NX), RTZ gives 3F800002, RUP gives 3F800003, RDN gives 3F800002.
- 00800000 x 3F000000, RNE: result 00000000, flags UF|NX. 80400000 x 3F800000 (DAZ): result 80000000, flags 0.
- Backpressure and reset:
  - Stream 6 ops (tags 0..5) while out_ready is held low 5 cycles. in_ready must drop, and all 6 results must emerge in tag order with no loss or duplication.
  - Then assert rst for 1 cycle with 2 ops in flight. out_valid must be 0 next cycle and no stale result may appear.

Source files
------------

// File: rtl/fmul_pipe_if.sv
// Operand-issue / result-writeback bundle for fmul_pipe.
// The slave side is the multiplier; the master side is the issue/writeback logic.
interface fmul_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned DATA_W = 1 + EXP_W + MAN_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [1:0]        r_mode;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  tag_out;
  logic [3:0]        flags;

  modport master (
    output in_valid, op1, op2, r_mode, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, flags
  );

  modport slave (
    input  in_valid, op1, op2, r_mode, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, flags
  );
endinterface

// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier: operand capture, S1 classify, S2 multiply,
// S3 normalise/round/pack. Global stall, DAZ, flush-to-zero, flags {NV,OF,UF,NX}.
module fmul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input logic        clk,
  input logic        rst,
  fmul_pipe_if.slave bus
);
  localparam int unsigned DATA_W = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned XE_W   = EXP_W + 2;
  localparam logic [XE_W-1:0] BIAS = XE_W'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {KNorm, KZero, KInf, KNan} kind_e;

  logic w_en;
  assign w_en         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_en;

  // Operand capture stage
  logic              r_in_valid;
  logic [DATA_W-1:0] r_in_op1, r_in_op2;
  logic [1:0]        r_in_mode;
  logic [TAG_W-1:0]  r_in_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_in_op1   <= '0;
      r_in_op2   <= '0;
      r_in_mode  <= '0;
      r_in_tag   <= '0;
    end else if (w_en) begin
      r_in_valid <= bus.in_valid;
      r_in_op1   <= bus.op1;
      r_in_op2   <= bus.op2;
      r_in_mode  <= bus.r_mode;
      r_in_tag   <= bus.tag_in;
    end
  end

  // S1: unpack and classify
  logic [EXP_W-1:0] w_e1, w_e2;
  logic [MAN_W-1:0] w_f1, w_f2;
  logic w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2, w_snan1, w_snan2;
  kind_e            w_kind;
  logic             w_nv;
  logic [XE_W-1:0]  w_s1_exp;

  assign w_e1    = r_in_op1[DATA_W-2 -: EXP_W];
  assign w_e2    = r_in_op2[DATA_W-2 -: EXP_W];
  assign w_f1    = r_in_op1[MAN_W-1:0];
  assign w_f2    = r_in_op2[MAN_W-1:0];
  assign w_zero1 = (w_e1 == '0);
  assign w_zero2 = (w_e2 == '0);
  assign w_inf1  = (&w_e1) && (w_f1 == '0);
  assign w_inf2  = (&w_e2) && (w_f2 == '0);
  assign w_nan1  = (&w_e1) && (w_f1 != '0);
  assign w_nan2  = (&w_e2) && (w_f2 != '0);
  assign w_snan1 = w_nan1 && !w_f1[MAN_W-1];
  assign w_snan2 = w_nan2 && !w_f2[MAN_W-1];
  assign w_s1_exp = XE_W'(w_e1) + XE_W'(w_e2) - BIAS;

  always_comb begin
    w_kind = KNorm;
    w_nv   = 1'b0;
    if (w_nan1 || w_nan2) begin
      w_kind = KNan;
      w_nv   = w_snan1 || w_snan2;
    end else if ((w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
      w_kind = KNan;
      w_nv   = 1'b1;
    end else if (w_inf1 || w_inf2) begin
      w_kind = KInf;
    end else if (w_zero1 || w_zero2) begin
      // Denormals land here too: exponent field zero is treated as zero.
      w_kind = KZero;
    end
  end

  logic             r_s1_valid, r_s1_sign, r_s1_nv;
  logic [XE_W-1:0]  r_s1_exp;
  logic [SIG_W-1:0] r_s1_m1, r_s1_m2;
  kind_e            r_s1_kind;
  logic [1:0]       r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_nv    <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_m1    <= '0;
      r_s1_m2    <= '0;
      r_s1_kind  <= KNorm;
      r_s1_mode  <= '0;
      r_s1_tag   <= '0;
    end else if (w_en) begin
      r_s1_valid <= r_in_valid;
      r_s1_sign  <= r_in_op1[DATA_W-1] ^ r_in_op2[DATA_W-1];
      r_s1_nv    <= w_nv;
      r_s1_exp   <= w_s1_exp;
      r_s1_m1    <= {1'b1, w_f1};
      r_s1_m2    <= {1'b1, w_f2};
      r_s1_kind  <= w_kind;
      r_s1_mode  <= r_in_mode;
      r_s1_tag   <= r_in_tag;
    end
  end

  // S2: significand multiply
  logic              r_s2_valid, r_s2_sign, r_s2_nv;
  logic [XE_W-1:0]   r_s2_exp;
  logic [PROD_W-1:0] r_s2_prod;
  kind_e             r_s2_kind;
  logic [1:0]        r_s2_mode;
  logic [TAG_W-1:0]  r_s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_nv    <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_prod  <= '0;
      r_s2_kind  <= KNorm;
      r_s2_mode  <= '0;
      r_s2_tag   <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_nv    <= r_s1_nv;
      r_s2_exp   <= r_s1_exp;
      r_s2_prod  <= PROD_W'(r_s1_m1) * PROD_W'(r_s1_m2);
      r_s2_kind  <= r_s1_kind;
      r_s2_mode  <= r_s1_mode;
      r_s2_tag   <= r_s1_tag;
    end
  end

  // S3: normalise, round, select, pack
  logic             w_norm, w_guard, w_sticky, w_inexact, w_inc, w_carry, w_ovf, w_unf;
  logic             w_use_inf;
  logic [MAN_W-1:0] w_frac;
  logic [MAN_W:0]   w_frac_rnd;
  logic [XE_W-1:0]  w_exp_fin;

  assign w_norm    = r_s2_prod[PROD_W-1];
  assign w_frac    = w_norm ? r_s2_prod[PROD_W-2 -: MAN_W] : r_s2_prod[PROD_W-3 -: MAN_W];
  assign w_guard   = w_norm ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
  assign w_sticky  = w_norm ? (|r_s2_prod[MAN_W-1:0]) : (|r_s2_prod[MAN_W-2:0]);
  assign w_inexact = w_guard || w_sticky;

  always_comb begin
    w_inc = 1'b0;
    unique case (r_s2_mode)
      2'b00:   w_inc = w_guard && (w_sticky || w_frac[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = w_inexact && r_s2_sign;
      default: w_inc = w_inexact && !r_s2_sign;
    endcase
  end

  // A rounding carry leaves the fraction field all-zero, which is already the renormalised value.
  assign w_frac_rnd = {1'b0, w_frac} + (MAN_W + 1)'(w_inc);
  assign w_carry    = w_frac_rnd[MAN_W];
  assign w_exp_fin  = r_s2_exp + XE_W'(w_norm) + XE_W'(w_carry);
  assign w_ovf      = $signed(w_exp_fin) >= EXP_MAX;
  assign w_unf      = $signed(w_exp_fin) <= $signed(XE_W'(0));
  assign w_use_inf  = (r_s2_mode == 2'b00) || ((r_s2_mode == 2'b11) && !r_s2_sign) ||
                      ((r_s2_mode == 2'b10) && r_s2_sign);

  logic [DATA_W-1:0] w_res;
  logic [3:0]        w_flags;

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    unique case (r_s2_kind)
      KNan: begin
        w_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
        w_flags = {r_s2_nv, 3'b000};
      end
      KInf:  w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      KZero: w_res = {r_s2_sign, {(DATA_W - 1){1'b0}}};
      default: begin
        if (w_ovf) begin
          w_flags = 4'b0101;
          w_res   = w_use_inf ? {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                              : {r_s2_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (w_unf) begin
          w_flags = 4'b0011;
          w_res   = {r_s2_sign, {(DATA_W - 1){1'b0}}};
        end else begin
          w_flags = {3'b000, w_inexact};
          w_res   = {r_s2_sign, w_exp_fin[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
        end
      end
    endcase
  end

  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic [TAG_W-1:0]  r_tag_out;
  logic [3:0]        r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag_out   <= '0;
      r_flags     <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      r_result    <= w_res;
      r_tag_out   <= r_s2_tag;
      r_flags     <= w_flags;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.tag_out   = r_tag_out;
  assign bus.flags     = r_flags;
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: special cases, rounding modes, overflow/underflow,
// backpressure ordering and mid-flight reset.
module tb_fmul_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fmul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Called at a negedge with out_ready high; issues one op and checks latency and outputs.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] mode, input logic [3:0] tag,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int lat;
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.r_mode   = mode;
    bus.tag_in   = tag;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'd3);
    check({name, "_res"}, bus.result, exp_res);
    check({name, "_flg"}, 32'(bus.flags), 32'(exp_fl));
    check({name, "_tag"}, 32'(bus.tag_out), 32'(tag));
  endtask

  int   sent, rcv, stall_cnt, stray;
  logic acc, was_stalled;
  logic [31:0] held;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.r_mode    = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_tag", 32'(bus.tag_out), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("one_x_two", 32'h3F800000, 32'h40000000, 2'b00, 4'd1, 32'h40000000, 4'b0000);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 2'b00, 4'd2, 32'h7FC00000, 4'b1000);
    run_op("zero_x_ninf", 32'h00000000, 32'hFF800000, 2'b00, 4'd3, 32'h7FC00000, 4'b1000);
    run_op("snan", 32'h7F800001, 32'h3F800000, 2'b00, 4'd4, 32'h7FC00000, 4'b1000);
    run_op("qnan", 32'h7FC00001, 32'h3F800000, 2'b00, 4'd5, 32'h7FC00000, 4'b0000);
    run_op("inf_x_neg", 32'h7F800000, 32'hC0000000, 2'b00, 4'd6, 32'hFF800000, 4'b0000);
    run_op("zero_x_neg", 32'h00000000, 32'hC0000000, 2'b00, 4'd7, 32'h80000000, 4'b0000);
    run_op("ovf_rne", 32'h7F7FFFFF, 32'h40000000, 2'b00, 4'd8, 32'h7F800000, 4'b0101);
    run_op("ovf_rtz", 32'h7F7FFFFF, 32'h40000000, 2'b01, 4'd9, 32'h7F7FFFFF, 4'b0101);
    run_op("ovf_rup_neg", 32'hFF7FFFFF, 32'h40000000, 2'b11, 4'd10, 32'hFF7FFFFF, 4'b0101);
    run_op("ovf_rdn_neg", 32'hFF7FFFFF, 32'h40000000, 2'b10, 4'd11, 32'hFF800000, 4'b0101);
    run_op("rnd_rne", 32'h3F800001, 32'h3F800001, 2'b00, 4'd12, 32'h3F800002, 4'b0001);
    run_op("rnd_rtz", 32'h3F800001, 32'h3F800001, 2'b01, 4'd13, 32'h3F800002, 4'b0001);
    run_op("rnd_rup", 32'h3F800001, 32'h3F800001, 2'b11, 4'd14, 32'h3F800003, 4'b0001);
    run_op("rnd_rdn", 32'h3F800001, 32'h3F800001, 2'b10, 4'd15, 32'h3F800002, 4'b0001);
    run_op("norm_shift", 32'h3FC00000, 32'h3FC00000, 2'b00, 4'd0, 32'h40100000, 4'b0000);
    run_op("underflow", 32'h00800000, 32'h3F000000, 2'b00, 4'd1, 32'h00000000, 4'b0011);
    run_op("daz", 32'h80400000, 32'h3F800000, 2'b00, 4'd2, 32'h80000000, 4'b0000);

    // Backpressure: six ops, out_ready low for five cycles while results are waiting.
    @(posedge clk);
    #1;
    sent        = 0;
    rcv         = 0;
    stall_cnt   = 0;
    was_stalled = 1'b0;
    held        = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      bus.out_ready = !(c >= 3 && c < 8);
      bus.in_valid  = (sent < 6);
      bus.op1       = 32'h3F800000;
      bus.op2       = 32'h40000000 | (32'(sent) << 16);
      bus.r_mode    = 2'b00;
      bus.tag_in    = 4'(sent);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check("bp_tag", 32'(bus.tag_out), 32'(rcv));
        check("bp_res", bus.result, 32'h40000000 | (32'(rcv) << 16));
        rcv++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        stall_cnt++;
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        if (was_stalled) check("bp_hold", bus.result, held);
        held        = bus.result;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_sent", 32'(sent), 32'd6);
    check("bp_rcv", 32'(rcv), 32'd6);
    check("bp_stalled", 32'(stall_cnt > 0), 32'd1);
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("bp_no_dup", 32'(stray), 32'd0);

    // Reset with two ops in flight.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op1      = 32'h3F800000;
    bus.op2      = 32'h40400000;
    bus.tag_in   = 4'd9;
    @(posedge clk);
    #1 bus.tag_in = 4'd10;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result", bus.result, 32'h0);
    check("mid_rst_tag", 32'(bus.tag_out), 32'd0);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("mid_rst_stale", 32'(stray), 32'd0);
    run_op("post_rst", 32'h40400000, 32'h40000000, 2'b00, 4'd3, 32'h40C00000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
